// File: rtl/rx_addr_filter_ctrl_pkg.sv
// Shared definitions for the RX destination-address filter: state encoding,
// MAC constants and a helper that picks wire byte k out of a 48-bit address.
package rx_addr_filter_ctrl_pkg;

   localparam int                MAC_W       = 48;
   localparam logic [MAC_W-1:0]  BCAST_ADDR  = 48'hffff_ffff_ffff;
   localparam logic [2:0]        LAST_DA_IDX = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DA       = 2'd1,
      ST_WAIT_EOF = 2'd2
   } state_t;

   // Byte 0 on the wire is the most significant byte of the address.
   function automatic logic [7:0] mac_byte(input logic [MAC_W-1:0] addr, input logic [2:0] k);
      logic [7:0] b;
      case (k)
         3'd0:    b = addr[47:40];
         3'd1:    b = addr[39:32];
         3'd2:    b = addr[31:24];
         3'd3:    b = addr[23:16];
         3'd4:    b = addr[15:8];
         3'd5:    b = addr[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rx_addr_filter_ctrl_match.sv
// Per-entry destination-address byte matcher. Keeps a sticky miss flag over
// the DA bytes of a frame; the miss output already folds in the byte being
// presented this cycle so the controller can decide on the 6th byte edge.
module mac_entry_match
   import rx_addr_filter_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [MAC_W-1:0] addr,
   input  logic [7:0]       rx_byte,
   input  logic [2:0]       byte_idx,
   input  logic             valid,
   input  logic             start,
   output logic             miss
);

   logic miss_r;
   logic byte_ne_s;

   // Miss including the current byte; start discards history of the old frame
   always_comb begin
      byte_ne_s = (rx_byte != mac_byte(addr, byte_idx));
      if (valid) begin
         if (start) begin
            miss = byte_ne_s;
         end else begin
            miss = miss_r | byte_ne_s;
         end
      end else begin
         miss = miss_r;
      end
   end

   // Sticky miss register, held across idle gaps
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         miss_r <= 1'b0;
      end else begin
         miss_r <= miss;
      end
   end

endmodule

// File: rtl/rx_addr_filter_ctrl.sv
// RX destination-address filter controller: sequences the per-entry matchers
// over the first six bytes of each frame, owns the address table, and merges
// table hits with broadcast/multicast/promiscuous policy into one decision.
module rx_addr_filter_ctrl
   import rx_addr_filter_ctrl_pkg::*;
#(
   parameter int NUM_ADDR = 4,
   parameter int IDX_W    = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_sof,
   input  logic             rx_eof,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [MAC_W-1:0] cfg_addr,
   input  logic             cfg_en,
   input  logic             promisc,
   input  logic             bcast_en,
   input  logic             mcast_en,
   output logic             dec_valid,
   output logic             dec_accept,
   output logic             dec_hit,
   output logic [IDX_W-1:0] dec_idx,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] accept_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   state_t            state_r;
   logic [2:0]        byte_cnt_r;
   logic              bcast_r;
   logic              group_r;
   logic [MAC_W-1:0]  tbl_addr_r [NUM_ADDR];
   logic [NUM_ADDR-1:0] tbl_en_r;
   logic              cfg_ready_r;
   logic              dec_valid_r;
   logic              dec_accept_r;
   logic              dec_hit_r;
   logic [IDX_W-1:0]  dec_idx_r;
   logic [CNT_W-1:0]  accept_cnt_r;
   logic [CNT_W-1:0]  drop_cnt_r;

   logic              start_s;
   logic              cfg_wr_s;
   logic              match_valid_s;
   logic              full_s;
   logic              runt_s;
   logic [2:0]        byte_idx_s;
   logic [MAC_W-1:0]  eff_addr_s [NUM_ADDR];
   logic [NUM_ADDR-1:0] eff_en_s;
   logic [NUM_ADDR-1:0] miss_s;
   logic [NUM_ADDR-1:0] hit_vec_s;
   logic              hit_s;
   logic [IDX_W-1:0]  hit_idx_s;
   logic              bcast_now_s;
   logic              accept_s;

   // A write landing in the same cycle as sof is forwarded so byte 0 sees it
   always_comb begin
      cfg_wr_s = cfg_valid & cfg_ready_r;
      for (int i = 0; i < NUM_ADDR; i++) begin
         if (cfg_wr_s && (cfg_idx == IDX_W'(i))) begin
            eff_addr_s[i] = cfg_addr;
            eff_en_s[i]   = cfg_en;
         end else begin
            eff_addr_s[i] = tbl_addr_r[i];
            eff_en_s[i]   = tbl_en_r[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_ADDR; g++) begin : g_entry
      mac_entry_match u_match (
         .clk      (clk),
         .reset_n  (reset_n),
         .addr     (eff_addr_s[g]),
         .rx_byte  (rx_data),
         .byte_idx (byte_idx_s),
         .valid    (match_valid_s),
         .start    (start_s),
         .miss     (miss_s[g])
      );
   end

   // Byte position, decision triggers, lowest-index hit and policy merge
   always_comb begin
      start_s       = rx_valid & rx_sof;
      byte_idx_s    = start_s ? 3'd0 : byte_cnt_r;
      match_valid_s = rx_valid & (start_s | (state_r == ST_DA));
      full_s        = rx_valid & ~rx_sof & (state_r == ST_DA) & (byte_cnt_r == LAST_DA_IDX);
      // Runt: eof before the 6th byte, or a new sof aborting an undecided frame
      runt_s        = (start_s & ((state_r == ST_DA) | rx_eof)) |
                      (rx_valid & ~rx_sof & rx_eof & (state_r == ST_DA) & (byte_cnt_r != LAST_DA_IDX));
      bcast_now_s   = (start_s ? 1'b1 : bcast_r) & (rx_data == mac_byte(BCAST_ADDR, byte_idx_s));
      hit_vec_s     = eff_en_s & ~miss_s;
      hit_s         = |hit_vec_s;
      hit_idx_s     = {IDX_W{1'b0}};
      for (int i = NUM_ADDR - 1; i >= 0; i--) begin
         if (hit_vec_s[i]) begin
            hit_idx_s = IDX_W'(i);
         end else begin
            hit_idx_s = hit_idx_s;
         end
      end
      accept_s = promisc | (bcast_now_s & bcast_en) | (group_r & ~bcast_now_s & mcast_en) | hit_s;
   end

   // Address table owned through the config handshake
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ADDR; i++) begin
            tbl_addr_r[i] <= {MAC_W{1'b0}};
         end
         tbl_en_r <= {NUM_ADDR{1'b0}};
      end else begin
         for (int i = 0; i < NUM_ADDR; i++) begin
            if (cfg_wr_s && (cfg_idx == IDX_W'(i))) begin
               tbl_addr_r[i] <= cfg_addr;
               tbl_en_r[i]   <= cfg_en;
            end
         end
      end
   end

   // Frame sequencing FSM with registered decision and config-ready outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         byte_cnt_r   <= 3'd0;
         bcast_r      <= 1'b0;
         group_r      <= 1'b0;
         cfg_ready_r  <= 1'b0;
         dec_valid_r  <= 1'b0;
         dec_accept_r <= 1'b0;
         dec_hit_r    <= 1'b0;
         dec_idx_r    <= {IDX_W{1'b0}};
      end else begin
         dec_valid_r <= full_s | runt_s;
         if (full_s) begin
            dec_accept_r <= accept_s;
            dec_hit_r    <= hit_s;
            dec_idx_r    <= hit_idx_s;
         end else if (runt_s) begin
            dec_accept_r <= 1'b0;
            dec_hit_r    <= 1'b0;
            dec_idx_r    <= {IDX_W{1'b0}};
         end
         if (start_s) begin
            byte_cnt_r  <= 3'd1;
            bcast_r     <= bcast_now_s;
            group_r     <= rx_data[0];
            state_r     <= rx_eof ? ST_IDLE : ST_DA;
            cfg_ready_r <= rx_eof;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  cfg_ready_r <= 1'b1;
               end
               ST_DA: begin
                  if (rx_valid && ((byte_cnt_r == LAST_DA_IDX) || rx_eof)) begin
                     state_r     <= rx_eof ? ST_IDLE : ST_WAIT_EOF;
                     cfg_ready_r <= rx_eof;
                  end else if (rx_valid) begin
                     byte_cnt_r  <= byte_cnt_r + 3'd1;
                     bcast_r     <= bcast_now_s;
                     cfg_ready_r <= 1'b0;
                  end else begin
                     cfg_ready_r <= 1'b0;
                  end
               end
               ST_WAIT_EOF: begin
                  if (rx_valid && rx_eof) begin
                     state_r     <= ST_IDLE;
                     cfg_ready_r <= 1'b1;
                  end else begin
                     cfg_ready_r <= 1'b0;
                  end
               end
               default: begin
                  state_r     <= ST_IDLE;
                  cfg_ready_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating frame counters; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         accept_cnt_r <= {CNT_W{1'b0}};
         drop_cnt_r   <= {CNT_W{1'b0}};
      end else if (cnt_clr) begin
         accept_cnt_r <= {CNT_W{1'b0}};
         drop_cnt_r   <= {CNT_W{1'b0}};
      end else if (dec_valid_r) begin
         if (dec_accept_r) begin
            if (accept_cnt_r != {CNT_W{1'b1}}) begin
               accept_cnt_r <= accept_cnt_r + CNT_W'(1);
            end
         end else begin
            if (drop_cnt_r != {CNT_W{1'b1}}) begin
               drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end
         end
      end
   end

   assign cfg_ready  = cfg_ready_r;
   assign dec_valid  = dec_valid_r;
   assign dec_accept = dec_accept_r;
   assign dec_hit    = dec_hit_r;
   assign dec_idx    = dec_idx_r;
   assign accept_cnt = accept_cnt_r;
   assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_rx_addr_filter_ctrl.sv
// Scoreboard bench for rx_addr_filter_ctrl. A second instance with narrow
// counters shares all inputs so counter saturation is reachable quickly.
`timescale 1ns/1ps
module tb_rx_addr_filter_ctrl;

   localparam int IDX_W = 2;
   localparam int CNT_W = 16;
   localparam int SAT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [IDX_W-1:0] cfg_idx = '0;
   logic [47:0]      cfg_addr = 48'h0;
   logic             cfg_en = 1'b0;
   logic             promisc = 1'b0, bcast_en = 1'b0, mcast_en = 1'b0, cnt_clr = 1'b0;

   logic             cfg_ready, dec_valid, dec_accept, dec_hit;
   logic [IDX_W-1:0] dec_idx;
   logic [CNT_W-1:0] accept_cnt, drop_cnt;
   logic             s_cfg_ready, s_dec_valid, s_dec_accept, s_dec_hit;
   logic [IDX_W-1:0] s_dec_idx;
   logic [SAT_W-1:0] s_accept_cnt, s_drop_cnt;

   rx_addr_filter_ctrl dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_sof(rx_sof), .rx_eof(rx_eof), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .promisc(promisc),
      .bcast_en(bcast_en), .mcast_en(mcast_en), .dec_valid(dec_valid),
      .dec_accept(dec_accept), .dec_hit(dec_hit), .dec_idx(dec_idx),
      .cnt_clr(cnt_clr), .accept_cnt(accept_cnt), .drop_cnt(drop_cnt));

   rx_addr_filter_ctrl #(.CNT_W(SAT_W)) dut_sat (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_sof(rx_sof), .rx_eof(rx_eof), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
      .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .promisc(promisc),
      .bcast_en(bcast_en), .mcast_en(mcast_en), .dec_valid(s_dec_valid),
      .dec_accept(s_dec_accept), .dec_hit(s_dec_hit), .dec_idx(s_dec_idx),
      .cnt_clr(cnt_clr), .accept_cnt(s_accept_cnt), .drop_cnt(s_drop_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic             acc;
      logic             hit;
      logic [IDX_W-1:0] idx;
      int               at;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   pend = 1'b0, pend_acc = 1'b0;
   int   m_acc = 0, m_drop = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int satv(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // Monitor: counters against the model, decisions against the queue
   always @(negedge clk) begin
      if (mon_en) begin
         check("accept_cnt", 64'(accept_cnt), 64'(satv(m_acc, CNT_W)));
         check("drop_cnt", 64'(drop_cnt), 64'(satv(m_drop, CNT_W)));
         check("sat_accept_cnt", 64'(s_accept_cnt), 64'(satv(m_acc, SAT_W)));
         check("sat_drop_cnt", 64'(s_drop_cnt), 64'(satv(m_drop, SAT_W)));
         while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            check("missing_dec", 64'(exp_q[0].at), 64'(cyc));
            void'(exp_q.pop_front());
         end
         if (dec_valid || s_dec_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_dec", 64'(1), 64'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("dec_cycle", 64'(cyc), 64'(e.at));
               check("dec_valid_pair", 64'({dec_valid, s_dec_valid}), 64'(2'b11));
               check("dec_accept", 64'(dec_accept), 64'(e.acc));
               check("dec_hit", 64'(dec_hit), 64'(e.hit));
               check("dec_idx", 64'(dec_idx), 64'(e.idx));
               check("sat_dec", 64'({s_dec_accept, s_dec_hit, s_dec_idx}), 64'({e.acc, e.hit, e.idx}));
               pend     = 1'b1;
               pend_acc = e.acc;
            end
         end
      end
   end

   // Counter model advances on the edge that ends the decision cycle
   always @(posedge clk) begin
      if (cnt_clr) begin
         m_acc = 0;
         m_drop = 0;
         pend = 1'b0;
      end else if (pend) begin
         if (pend_acc) m_acc++;
         else m_drop++;
         pend = 1'b0;
      end
   end

   task automatic push_exp(input bit a, input bit h, input logic [IDX_W-1:0] x);
      exp_t e;
      e.acc = a; e.hit = h; e.idx = x; e.at = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [47:0] addr, input logic en);
      int n;
      n = 0;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_idx = idx; cfg_addr = addr; cfg_en = en;
      while (!cfg_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("cfg_write_timeout", 64'(n >= 20), 64'(0));
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // cfg_mode: 0 none, 1 hold cfg_valid from byte 1 on, 2 pulse cfg_valid with sof
   task automatic send_frame(input logic [47:0] da, input int nb, input int gaps,
                             input bit eof_en, input bit abort_prev, input int cfg_mode,
                             input bit e_acc, input bit e_hit, input logic [IDX_W-1:0] e_idx);
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_sof   = (i == 0);
         rx_eof   = eof_en && (i == nb - 1);
         rx_data  = (i < 6) ? da[47 - 8*i -: 8] : 8'h5a;
         if (abort_prev && i == 0) push_exp(1'b0, 1'b0, '0);
         if (i == 5 || (eof_en && nb < 6 && i == nb - 1)) push_exp(e_acc, e_hit, e_idx);
         if (cfg_mode == 1 && i >= 1) begin
            cfg_valid = 1'b1;
            check("cfg_ready_busy", 64'({cfg_ready, s_cfg_ready}), 64'(2'b00));
         end
         if (cfg_mode == 2) begin
            if (i == 0) check("cfg_ready_sof", 64'(cfg_ready), 64'(1));
            cfg_valid = (i == 0);
         end
         if (gaps > 0 && (i == 1 || i == 3)) begin
            for (int g = 0; g < gaps; g++) begin
               @(negedge clk);
               rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
               if (cfg_mode == 1) check("cfg_ready_gap", 64'(cfg_ready), 64'(0));
            end
         end
      end
      @(negedge clk);
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
      if (cfg_mode == 1) check("cfg_ready_after_eof", 64'({cfg_ready, s_cfg_ready}), 64'(2'b11));
      if (cfg_mode == 2) cfg_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
      check("rst_dec", 64'({dec_valid, dec_accept, dec_hit, dec_idx}), 64'(0));
      check("rst_cnts", 64'({accept_cnt, drop_cnt}), 64'(0));
      reset_n = 1'b1;
      mon_en  = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_cfg_ready", 64'(cfg_ready), 64'(1));

      // Unicast hit with idle gaps inside the DA
      cfg_write(2'd2, 48'h0011_2233_4455, 1'b1);
      send_frame(48'h0011_2233_4455, 8, 2, 1, 0, 0, 1'b1, 1'b1, 2'd2);

      // Broadcast blocked by bcast_en=0 even with mcast_en=1, then allowed
      mcast_en = 1'b1;
      send_frame(48'hffff_ffff_ffff, 6, 0, 1, 0, 0, 1'b0, 1'b0, 2'd0);
      bcast_en = 1'b1;
      send_frame(48'hffff_ffff_ffff, 6, 0, 1, 0, 0, 1'b1, 1'b0, 2'd0);

      // Multicast, promiscuous, and neither
      bcast_en = 1'b0;
      send_frame(48'h0100_5e00_0001, 7, 0, 1, 0, 0, 1'b1, 1'b0, 2'd0);
      mcast_en = 1'b0; promisc = 1'b1;
      send_frame(48'h0100_5e00_0001, 7, 0, 1, 0, 0, 1'b1, 1'b0, 2'd0);
      promisc = 1'b0;
      send_frame(48'h0100_5e00_0001, 7, 0, 1, 0, 0, 1'b0, 1'b0, 2'd0);

      // Lowest index wins; disabled entries never hit; last-byte mismatch misses
      cfg_write(2'd1, 48'h0a0b_0c0d_0e0f, 1'b1);
      cfg_write(2'd3, 48'h0a0b_0c0d_0e0f, 1'b1);
      send_frame(48'h0a0b_0c0d_0e0f, 6, 1, 1, 0, 0, 1'b1, 1'b1, 2'd1);
      cfg_write(2'd1, 48'h0a0b_0c0d_0e0f, 1'b0);
      send_frame(48'h0a0b_0c0d_0e0f, 6, 0, 1, 0, 0, 1'b1, 1'b1, 2'd3);
      send_frame(48'h0a0b_0c0d_0e00, 6, 0, 1, 0, 0, 1'b0, 1'b0, 2'd0);

      // Runt, then a frame aborted mid-DA by the next sof
      send_frame(48'h0011_2233_4455, 4, 0, 1, 0, 0, 1'b0, 1'b0, 2'd0);
      send_frame(48'h0011_2233_4455, 3, 0, 0, 0, 0, 1'b0, 1'b0, 2'd0);
      send_frame(48'h0011_2233_4455, 6, 0, 1, 1, 0, 1'b1, 1'b1, 2'd2);

      // Write held during a frame completes only after eof
      cfg_idx = 2'd0; cfg_addr = 48'h02aa_bbcc_ddee; cfg_en = 1'b1;
      send_frame(48'h02aa_bbcc_ddee, 8, 1, 1, 0, 1, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      cfg_valid = 1'b0;
      send_frame(48'h02aa_bbcc_ddee, 6, 0, 1, 0, 0, 1'b1, 1'b1, 2'd0);

      // Write coincident with sof is used by that same frame
      cfg_idx = 2'd1; cfg_addr = 48'h1234_5678_9abc; cfg_en = 1'b1;
      send_frame(48'h1234_5678_9abc, 6, 0, 1, 0, 2, 1'b1, 1'b1, 2'd1);

      // Enough runts to saturate the narrow counters
      for (int k = 0; k < 20; k++) begin
         send_frame(48'h0011_2233_4455, 2, 0, 1, 0, 0, 1'b0, 1'b0, 2'd0);
      end
      @(negedge clk);
      check("sat_drop_pinned", 64'(s_drop_cnt), 64'(4'hf));

      // Clear coincident with a decision strobe leaves counters at zero
      send_frame(48'h0011_2233_4455, 2, 0, 1, 0, 0, 1'b0, 1'b0, 2'd0);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("clr_over_inc", 64'({accept_cnt, drop_cnt}), 64'(0));
      send_frame(48'h1234_5678_9abc, 6, 0, 1, 0, 0, 1'b1, 1'b1, 2'd1);

      repeat (4) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
